// File: rtl/ex2_accumulator.sv
// ex2_accumulator: memory-stage HI/LO accumulator and result select.
// Holds the 64-bit HI/LO pair and applies MULT/MTHI/MTLO (and MADD/MSUB).
// Picks the stage result from ALUIn, HI, LO or MULIn[31:0], with its flags.
// Ports:
//   Clock, nReset          clock (rising) / async active-low reset
//   ALUC/ALUZ/ALUO/ALUN    flags from execute stage 1 (Z/N unused)
//   ACCEn                  accumulator write enable for this instruction
//   MULOp                  1: Func is SPECIAL2, 0: Func is SPECIAL
//   ALUIn[31:0]            ALU result / memory address
//   MULIn[63:0]            product, zero-extended Rs, or CLO/CLZ count
//   Func[5:0]              instruction funct field
//   Out[31:0], C/Z/O/N     stage result and flags
// Build option: define ACC_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.

module ex2_accumulator (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        ALUC,
   input  logic        ALUZ,
   input  logic        ALUO,
   input  logic        ALUN,
   input  logic        ACCEn,
   input  logic        MULOp,
   input  logic [31:0] ALUIn,
   input  logic [63:0] MULIn,
   input  logic [5:0]  Func,
   output logic [31:0] Out,
   output logic        C,
   output logic        Z,
   output logic        O,
   output logic        N
);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_MADD  = 6'h00;
   localparam logic [5:0] F_MADDU = 6'h01;
   localparam logic [5:0] F_MUL   = 6'h02;
   localparam logic [5:0] F_MSUB  = 6'h04;
   localparam logic [5:0] F_MSUBU = 6'h05;
   localparam logic [5:0] F_CLZ   = 6'h20;
   localparam logic [5:0] F_CLO   = 6'h21;

   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_mfhi;
   logic        w_mflo;
   logic        w_mulsel;
   logic        w_alusel;
   logic        w_mult;
   logic        w_mthi;
   logic        w_mtlo;
   logic        w_madd;
   logic        w_msub;
   logic [63:0] w_acc;
   logic [63:0] w_acc_add;
   logic [63:0] w_acc_sub;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;
   logic        w_unused;

   // Z/N are recomputed from Out; the incoming ones are not needed.
   assign w_unused = ALUZ ^ ALUN;

   // Result-select decode
   assign w_mfhi   = !MULOp && (Func == F_MFHI);
   assign w_mflo   = !MULOp && (Func == F_MFLO);
   assign w_mulsel = MULOp &&
                     ((Func == F_MUL) ||
                      (Func == F_CLZ) ||
                      (Func == F_CLO));
   assign w_alusel = !(w_mfhi || w_mflo || w_mulsel);

   // Accumulator-write decode
   assign w_mult = !MULOp &&
                   ((Func == F_MULT) || (Func == F_MULTU));
   assign w_mthi = !MULOp && (Func == F_MTHI);
   assign w_mtlo = !MULOp && (Func == F_MTLO);

`ifdef ACC_MADD_EN
   assign w_madd = MULOp &&
                   ((Func == F_MADD) || (Func == F_MADDU));
   assign w_msub = MULOp &&
                   ((Func == F_MSUB) || (Func == F_MSUBU));
`else
   assign w_madd = 1'b0;
   assign w_msub = 1'b0;
`endif

   // Signedness is already folded into MULIn, so a plain
   // 64-bit wrap-around add/sub covers both variants.
   assign w_acc     = {r_hi, r_lo};
   assign w_acc_add = w_acc + MULIn;
   assign w_acc_sub = w_acc - MULIn;

   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (ACCEn) begin
         unique case (1'b1)
            w_mult: begin
               w_hi_nxt = MULIn[63:32];
               w_lo_nxt = MULIn[31:0];
            end
            w_mthi: w_hi_nxt = MULIn[31:0];
            w_mtlo: w_lo_nxt = MULIn[31:0];
            w_madd: begin
               w_hi_nxt = w_acc_add[63:32];
               w_lo_nxt = w_acc_add[31:0];
            end
            w_msub: begin
               w_hi_nxt = w_acc_sub[63:32];
               w_lo_nxt = w_acc_sub[31:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         r_hi <= w_hi_nxt;
         r_lo <= w_lo_nxt;
      end
   end

   // Stage result: reads the pre-write HI/LO (no bypass).
   always_comb begin
      Out = ALUIn;
      unique case (1'b1)
         w_mfhi:   Out = r_hi;
         w_mflo:   Out = r_lo;
         w_mulsel: Out = MULIn[31:0];
         default:  Out = ALUIn;
      endcase
   end

   assign Z = (Out == 32'd0);
   assign N = Out[31];
   assign C = w_alusel & ALUC;
   assign O = w_alusel & ALUO;

endmodule

// File: tb/tb_ex2_accumulator.sv
// tb_ex2_accumulator: directed checks for ex2_accumulator.
// Covers reset, MULT/MTHI/MTLO, MADD/MSUB (per build), selection, flags.

module tb_ex2_accumulator;

   logic        Clock;
   logic        nReset;
   logic        ALUC;
   logic        ALUZ;
   logic        ALUO;
   logic        ALUN;
   logic        ACCEn;
   logic        MULOp;
   logic [31:0] ALUIn;
   logic [63:0] MULIn;
   logic [5:0]  Func;
   logic [31:0] Out;
   logic        C;
   logic        Z;
   logic        O;
   logic        N;

   int total;
   int bad;

   ex2_accumulator dut (
      .Clock (Clock),
      .nReset(nReset),
      .ALUC  (ALUC),
      .ALUZ  (ALUZ),
      .ALUO  (ALUO),
      .ALUN  (ALUN),
      .ACCEn (ACCEn),
      .MULOp (MULOp),
      .ALUIn (ALUIn),
      .MULIn (MULIn),
      .Func  (Func),
      .Out   (Out),
      .C     (C),
      .Z     (Z),
      .O     (O),
      .N     (N)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the falling edge; checks follow #1 later.
   task automatic drive(input logic        op,
                        input logic [5:0]  fn,
                        input logic        en,
                        input logic [31:0] ai,
                        input logic [63:0] mi);
      MULOp = op;
      Func  = fn;
      ACCEn = en;
      ALUIn = ai;
      MULIn = mi;
      #1;
   endtask

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic rd_hilo(input string tag,
                          input logic [31:0] hi,
                          input logic [31:0] lo);
      drive(1'b0, 6'h10, 1'b0, 32'hDEAD_BEEF, 64'd0);
      chk({tag, "_hi"}, {32'd0, Out}, {32'd0, hi});
      drive(1'b0, 6'h12, 1'b0, 32'hDEAD_BEEF, 64'd0);
      chk({tag, "_lo"}, {32'd0, Out}, {32'd0, lo});
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      nReset = 1'b0;
      ALUC   = 1'b0;
      ALUZ   = 1'b0;
      ALUO   = 1'b0;
      ALUN   = 1'b0;
      @(negedge Clock);

      // Reset state
      drive(1'b0, 6'h10, 1'b0, 32'hA5A5_A5A5, 64'd0);
      chk("rst_mfhi", {32'd0, Out}, 64'd0);
      chk("rst_z", {63'd0, Z}, 64'd1);
      drive(1'b0, 6'h12, 1'b0, 32'hA5A5_A5A5, 64'd0);
      chk("rst_mflo", {32'd0, Out}, 64'd0);
      drive(1'b0, 6'h20, 1'b0, 32'hA5A5_A5A5, 64'd0);
      chk("rst_pass", {32'd0, Out}, 64'hA5A5_A5A5);
      tick();
      nReset = 1'b1;

      // MULT with ACCEn=0 leaves HI/LO alone
      drive(1'b0, 6'h18, 1'b0, 32'h1, 64'h2_FFFF_FFFE);
      tick();
      rd_hilo("mult_dis", 32'd0, 32'd0);

      // MULT with ACCEn=1; same cycle Out = ALUIn
      ALUC = 1'b1;
      drive(1'b0, 6'h18, 1'b1, 32'h1111, 64'h2_FFFF_FFFE);
      chk("mult_out", {32'd0, Out}, 64'h1111);
      tick();
      drive(1'b0, 6'h10, 1'b0, 32'd0, 64'd0);
      chk("mult_hi", {32'd0, Out}, 64'h2);
      chk("mult_hi_n", {63'd0, N}, 64'd0);
      drive(1'b0, 6'h12, 1'b0, 32'd0, 64'd0);
      chk("mult_lo", {32'd0, Out}, 64'hFFFF_FFFE);
      chk("mult_lo_n", {63'd0, N}, 64'd1);
      chk("mflo_c", {63'd0, C}, 64'd0);
      ALUC = 1'b0;

      // MTHI then MTLO
      drive(1'b0, 6'h11, 1'b1, 32'd0, 64'hFFFF_0000_1234_5678);
      tick();
      drive(1'b0, 6'h13, 1'b1, 32'd0, 64'h0000_FFFF_9ABC_DEF0);
      tick();
      rd_hilo("mt", 32'h1234_5678, 32'h9ABC_DEF0);

      // MADD / MSUB
      drive(1'b0, 6'h19, 1'b1, 32'd0, 64'h0_FFFF_FFFF);
      tick();
      drive(1'b1, 6'h00, 1'b1, 32'h77, 64'd1);
      chk("madd_out", {32'd0, Out}, 64'h77);
      tick();
`ifdef ACC_MADD_EN
      rd_hilo("madd", 32'h1, 32'h0);
`else
      rd_hilo("madd", 32'h0, 32'hFFFF_FFFF);
`endif
      drive(1'b1, 6'h04, 1'b1, 32'h0, 64'd2);
      tick();
`ifdef ACC_MADD_EN
      rd_hilo("msub", 32'h0, 32'hFFFF_FFFE);
`else
      rd_hilo("msub", 32'h0, 32'hFFFF_FFFF);
`endif

      // ALU pass-through with flags
      ALUC = 1'b1;
      ALUO = 1'b1;
      drive(1'b0, 6'h20, 1'b0, 32'h8000_0000, 64'd5);
      chk("pass_out", {32'd0, Out}, 64'h8000_0000);
      chk("pass_flags", {60'd0, C, Z, O, N}, 64'b1011);

      // MUL selection clears C/O
      drive(1'b1, 6'h02, 1'b0, 32'hFFFF, 64'h0_0000_0006);
      chk("mul_out", {32'd0, Out}, 64'h6);
      chk("mul_flags", {60'd0, C, Z, O, N}, 64'b0000);

      // CLZ with ACCEn=1 does not touch the accumulator
      ALUC = 1'b0;
      ALUO = 1'b0;
      drive(1'b1, 6'h20, 1'b1, 32'hFFFF, 64'd32);
      chk("clz_out", {32'd0, Out}, 64'd32);
      tick();
`ifdef ACC_MADD_EN
      rd_hilo("clz", 32'h0, 32'hFFFF_FFFE);
`else
      rd_hilo("clz", 32'h0, 32'hFFFF_FFFF);
`endif

      // Zero result through ALU path
      drive(1'b0, 6'h21, 1'b0, 32'd0, 64'd9);
      chk("zero_z", {63'd0, Z}, 64'd1);

      // Asynchronous reset mid-cycle
      drive(1'b0, 6'h11, 1'b1, 32'd0, 64'hCAFE_F00D);
      tick();
      drive(1'b0, 6'h10, 1'b0, 32'd0, 64'd0);
      chk("pre_arst", {32'd0, Out}, 64'hCAFE_F00D);
      nReset = 1'b0;
      #1;
      chk("arst_hi", {32'd0, Out}, 64'd0);

      // A write pending while reset is held is lost
      drive(1'b0, 6'h13, 1'b1, 32'd0, 64'h5555_5555);
      tick();
      nReset = 1'b1;
      rd_hilo("arst_pend", 32'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
